regfile_scoreboard: RTL and testbench

- Parametrised successor to the single-cycle MIPS register file: configurable data width and register count, hardwired zero register, optional write-to-read bypass, and a per-register pending (scoreboard) vector.
- Pending bits track outstanding multi-cycle producers such as loads from the memory subsystem.
- Sits in the decode stage of the pipelined core. The hazard unit consumes Pending_1, Pending_2 and Stall.

---
 rtl/regfile_scoreboard.sv | 118 +++++++++++
 tb/tb_regfile_scoreboard.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with hardwired zero register, optional
// write-to-read bypass and a per-register pending (scoreboard) vector
// used by the hazard unit to stall on outstanding multi-cycle producers.
module regfile_scoreboard #(
    parameter int              DATA_W   = 32,
    parameter int              ADDR_W   = 5,
    parameter int              BYPASS   = 1,
    parameter int              GP_INDEX = 28,
    parameter logic [31:0]     GP_RESET = 32'h10008000,
    parameter int              SP_INDEX = 29,
    parameter logic [31:0]     SP_RESET = 32'h00000180
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] Write_register,
    input  logic [DATA_W-1:0] Write_Data,
    input  logic [ADDR_W-1:0] Read_register_1,
    input  logic [ADDR_W-1:0] Read_register_2,
    output logic [DATA_W-1:0] Read_data_1,
    output logic [DATA_W-1:0] Read_data_2,
    input  logic              Issue_valid,
    input  logic [ADDR_W-1:0] Issue_register,
    output logic              Pending_1,
    output logic              Pending_2,
    output logic              Stall,
    output logic [ADDR_W:0]   Pending_count
);

    localparam int NREG = 2 ** ADDR_W;

    // GP/SP reset constants are 32-bit; resize them to the datapath width
    localparam logic [DATA_W-1:0] GP_INIT = DATA_W'(GP_RESET);
    localparam logic [DATA_W-1:0] SP_INIT = DATA_W'(SP_RESET);

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   pend;
    logic [NREG-1:0]   pend_next;
    logic [ADDR_W:0]   count_next;
    logic              wr_en;
    logic              byp_1;
    logic              byp_2;

    // A write to register 0 is discarded everywhere, including the bypass path
    assign wr_en = RegWrite && (Write_register != '0);
    assign byp_1 = (BYPASS != 0) && wr_en && (Write_register == Read_register_1);
    assign byp_2 = (BYPASS != 0) && wr_en && (Write_register == Read_register_2);

    // Register array: reset to zero except GP/SP, then ordinary writes
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NREG; i++) begin
                if (i == GP_INDEX)
                    regs[i] <= GP_INIT;
                else if (i == SP_INDEX)
                    regs[i] <= SP_INIT;
                else
                    regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[Write_register] <= Write_Data;
        end
    end

    // Next pending vector: write clears, issue sets afterwards so the newer producer wins
    always_comb begin
        pend_next = pend;
        if (RegWrite)
            pend_next[Write_register] = 1'b0;
        if (Issue_valid)
            pend_next[Issue_register] = 1'b1;
        pend_next[0] = 1'b0;
    end

    // Popcount of the next vector so the registered count tracks pend exactly
    always_comb begin
        count_next = '0;
        for (int i = 1; i < NREG; i++)
            count_next = count_next + (ADDR_W+1)'(pend_next[i]);
    end

    // Scoreboard state; reset discards every outstanding producer
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pend          <= '0;
            Pending_count <= '0;
        end else begin
            pend          <= pend_next;
            Pending_count <= count_next;
        end
    end

    // Read port 1: stored value, overridden by same-cycle write when bypassing
    always_comb begin
        Read_data_1 = regs[Read_register_1];
        if (byp_1)
            Read_data_1 = Write_Data;
        if (Read_register_1 == '0)
            Read_data_1 = '0;
    end

    // Read port 2: independent copy of port 1 logic
    always_comb begin
        Read_data_2 = regs[Read_register_2];
        if (byp_2)
            Read_data_2 = Write_Data;
        if (Read_register_2 == '0)
            Read_data_2 = '0;
    end

    // Hazard flags; a bypassed write satisfies the reader this cycle
    always_comb begin
        Pending_1 = pend[Read_register_1] && (Read_register_1 != '0) && !byp_1;
        Pending_2 = pend[Read_register_2] && (Read_register_2 != '0) && !byp_2;
        Stall     = Pending_1 || Pending_2;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one instance with bypass enabled,
// one without, driven from the same stimulus.
module tb_regfile_scoreboard;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        RegWrite = 1'b0;
    logic [4:0]  Write_register = '0;
    logic [31:0] Write_Data = '0;
    logic [4:0]  Read_register_1 = '0;
    logic [4:0]  Read_register_2 = '0;
    logic        Issue_valid = 1'b0;
    logic [4:0]  Issue_register = '0;

    logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;
    logic        b_p1, b_p2, b_stall, n_p1, n_p2, n_stall;
    logic [5:0]  b_cnt, n_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    regfile_scoreboard #(.BYPASS(1)) u_byp (
        .CLK(CLK), .RESET(RESET), .RegWrite(RegWrite),
        .Write_register(Write_register), .Write_Data(Write_Data),
        .Read_register_1(Read_register_1), .Read_register_2(Read_register_2),
        .Read_data_1(b_rd1), .Read_data_2(b_rd2),
        .Issue_valid(Issue_valid), .Issue_register(Issue_register),
        .Pending_1(b_p1), .Pending_2(b_p2), .Stall(b_stall),
        .Pending_count(b_cnt)
    );

    regfile_scoreboard #(.BYPASS(0)) u_nob (
        .CLK(CLK), .RESET(RESET), .RegWrite(RegWrite),
        .Write_register(Write_register), .Write_Data(Write_Data),
        .Read_register_1(Read_register_1), .Read_register_2(Read_register_2),
        .Read_data_1(n_rd1), .Read_data_2(n_rd2),
        .Issue_valid(Issue_valid), .Issue_register(Issue_register),
        .Pending_1(n_p1), .Pending_2(n_p2), .Stall(n_stall),
        .Pending_count(n_cnt)
    );

    // Advance one rising edge; inputs change and outputs settle 1 time unit later
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        RESET = 1'b0; RegWrite = 1'b0; Issue_valid = 1'b0;
        Write_register = '0; Write_Data = '0; Issue_register = '0;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 32; i++) begin
            Read_register_1 = 5'(i);
            Read_register_2 = 5'(i);
            #1;
            exp = (i == 28) ? 32'h10008000 : (i == 29) ? 32'h00000180 : 32'h0;
            vectors++;
            if (b_rd1 !== exp || n_rd2 !== exp) begin
                $display("FAIL reset_reg%0d: got byp=%h nob=%h, expected %h", i, b_rd1, n_rd2, exp);
                miscompares++;
            end
        end
        vectors++;
        if (b_cnt !== 6'd0 || n_cnt !== 6'd0 || b_stall !== 1'b0) begin
            $display("FAIL reset_count: got byp=%0d nob=%0d stall=%b, expected 0 0 0", b_cnt, n_cnt, b_stall);
            miscompares++;
        end
    endtask

    task automatic test_write();
        RegWrite = 1'b1; Write_register = 5'd8; Write_Data = 32'hDEADBEEF;
        tick();
        idle_inputs();
        Read_register_1 = 5'd8; Read_register_2 = 5'd8;
        #1;
        vectors++;
        if (b_rd1 !== 32'hDEADBEEF || n_rd1 !== 32'hDEADBEEF) begin
            $display("FAIL write_reg8: got byp=%h nob=%h, expected deadbeef", b_rd1, n_rd1);
            miscompares++;
        end
        vectors++;
        if (b_rd2 !== 32'hDEADBEEF || n_rd2 !== 32'hDEADBEEF) begin
            $display("FAIL dual_port_same_reg: got byp=%h nob=%h, expected deadbeef", b_rd2, n_rd2);
            miscompares++;
        end
        RegWrite = 1'b1; Write_register = 5'd0; Write_Data = 32'h1234;
        Read_register_1 = 5'd0;
        #1;
        vectors++;
        if (b_rd1 !== 32'h0) begin
            $display("FAIL zero_no_bypass: got %h, expected 0", b_rd1);
            miscompares++;
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (b_rd1 !== 32'h0 || n_rd1 !== 32'h0) begin
            $display("FAIL zero_protect: got byp=%h nob=%h, expected 0", b_rd1, n_rd1);
            miscompares++;
        end
    endtask

    task automatic test_bypass();
        Read_register_1 = 5'd9; Read_register_2 = 5'd8;
        RegWrite = 1'b1; Write_register = 5'd9; Write_Data = 32'hA5A5A5A5;
        #1;
        vectors++;
        if (b_rd1 !== 32'hA5A5A5A5) begin
            $display("FAIL bypass_same_cycle: got %h, expected a5a5a5a5", b_rd1);
            miscompares++;
        end
        vectors++;
        if (n_rd1 !== 32'h0) begin
            $display("FAIL nobypass_old_value: got %h, expected 0", n_rd1);
            miscompares++;
        end
        vectors++;
        if (b_rd2 !== 32'hDEADBEEF) begin
            $display("FAIL bypass_other_port: got %h, expected deadbeef", b_rd2);
            miscompares++;
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (n_rd1 !== 32'hA5A5A5A5 || b_rd1 !== 32'hA5A5A5A5) begin
            $display("FAIL bypass_next_cycle: got byp=%h nob=%h, expected a5a5a5a5", b_rd1, n_rd1);
            miscompares++;
        end
    endtask

    task automatic test_scoreboard();
        Issue_valid = 1'b1; Issue_register = 5'd10;
        tick();
        idle_inputs();
        Read_register_1 = 5'd10; Read_register_2 = 5'd10;
        #1;
        vectors++;
        if (b_p1 !== 1'b1 || b_p2 !== 1'b1 || b_stall !== 1'b1 || b_cnt !== 6'd1) begin
            $display("FAIL issue_pending: got p1=%b p2=%b stall=%b cnt=%0d, expected 1 1 1 1", b_p1, b_p2, b_stall, b_cnt);
            miscompares++;
        end
        vectors++;
        if (n_p1 !== 1'b1 || n_cnt !== 6'd1) begin
            $display("FAIL issue_pending_nob: got p1=%b cnt=%0d, expected 1 1", n_p1, n_cnt);
            miscompares++;
        end
        Read_register_2 = 5'd8;
        RegWrite = 1'b1; Write_register = 5'd10; Write_Data = 32'h55;
        #1;
        vectors++;
        if (b_p1 !== 1'b0 || b_stall !== 1'b0) begin
            $display("FAIL write_clears_same_cycle: got p1=%b stall=%b, expected 0 0", b_p1, b_stall);
            miscompares++;
        end
        vectors++;
        if (n_p1 !== 1'b1 || n_stall !== 1'b1) begin
            $display("FAIL nob_pending_until_edge: got p1=%b stall=%b, expected 1 1", n_p1, n_stall);
            miscompares++;
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (b_p1 !== 1'b0 || n_p1 !== 1'b0 || b_cnt !== 6'd0 || n_cnt !== 6'd0) begin
            $display("FAIL write_clears_after_edge: got p1=%b/%b cnt=%0d/%0d, expected 0 0 0 0", b_p1, n_p1, b_cnt, n_cnt);
            miscompares++;
        end
    endtask

    task automatic test_simultaneous();
        Issue_valid = 1'b1; Issue_register = 5'd11;
        RegWrite = 1'b1; Write_register = 5'd11; Write_Data = 32'h77;
        tick();
        idle_inputs();
        Read_register_1 = 5'd11;
        #1;
        vectors++;
        if (b_p1 !== 1'b1 || b_cnt !== 6'd1) begin
            $display("FAIL set_wins: got p1=%b cnt=%0d, expected 1 1", b_p1, b_cnt);
            miscompares++;
        end
        Issue_valid = 1'b1; Issue_register = 5'd11;
        tick();
        idle_inputs();
        vectors++;
        if (b_cnt !== 6'd1) begin
            $display("FAIL reissue_no_double: got cnt=%0d, expected 1", b_cnt);
            miscompares++;
        end
        Issue_valid = 1'b1; Issue_register = 5'd0;
        tick();
        idle_inputs();
        Read_register_1 = 5'd0;
        #1;
        vectors++;
        if (b_cnt !== 6'd1 || b_p1 !== 1'b0 || n_p1 !== 1'b0) begin
            $display("FAIL issue_zero_ignored: got cnt=%0d p1=%b/%b, expected 1 0 0", b_cnt, b_p1, n_p1);
            miscompares++;
        end
        RegWrite = 1'b1; Write_register = 5'd12; Write_Data = 32'h1;
        tick();
        idle_inputs();
        vectors++;
        if (b_cnt !== 6'd1 || n_cnt !== 6'd1) begin
            $display("FAIL write_nonpending: got cnt=%0d/%0d, expected 1 1", b_cnt, n_cnt);
            miscompares++;
        end
        RegWrite = 1'b1; Write_register = 5'd11; Write_Data = 32'h2;
        tick();
        idle_inputs();
        vectors++;
        if (b_cnt !== 6'd0) begin
            $display("FAIL final_clear: got cnt=%0d, expected 0", b_cnt);
            miscompares++;
        end
    endtask

    task automatic test_full_count();
        for (int i = 0; i < 32; i++) begin
            Issue_valid = 1'b1; Issue_register = 5'(i);
            tick();
        end
        idle_inputs();
        vectors++;
        if (b_cnt !== 6'd31 || n_cnt !== 6'd31) begin
            $display("FAIL full_count: got %0d/%0d, expected 31", b_cnt, n_cnt);
            miscompares++;
        end
        RESET = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        RegWrite = 1'b1; Write_register = 5'd3; Write_Data = 32'h7;
        tick();
        idle_inputs();
        for (int i = 3; i <= 5; i++) begin
            Issue_valid = 1'b1; Issue_register = 5'(i);
            tick();
        end
        idle_inputs();
        Read_register_1 = 5'd3; Read_register_2 = 5'd4;
        #1;
        vectors++;
        if (b_cnt !== 6'd3 || b_rd1 !== 32'h7 || b_p2 !== 1'b1) begin
            $display("FAIL pre_reset_state: got cnt=%0d rd1=%h p2=%b, expected 3 7 1", b_cnt, b_rd1, b_p2);
            miscompares++;
        end
        RESET = 1'b1;
        RegWrite = 1'b1; Write_register = 5'd6; Write_Data = 32'hFF;
        Issue_valid = 1'b1; Issue_register = 5'd7;
        tick();
        idle_inputs();
        Read_register_1 = 5'd3; Read_register_2 = 5'd6;
        #1;
        vectors++;
        if (b_cnt !== 6'd0 || n_cnt !== 6'd0 || b_rd1 !== 32'h0 || b_rd2 !== 32'h0 || n_rd2 !== 32'h0) begin
            $display("FAIL reset_mid: got cnt=%0d/%0d reg3=%h reg6=%h/%h, expected 0 0 0 0 0", b_cnt, n_cnt, b_rd1, b_rd2, n_rd2);
            miscompares++;
        end
        Read_register_1 = 5'd4; Read_register_2 = 5'd28;
        #1;
        vectors++;
        if (b_p1 !== 1'b0 || b_stall !== 1'b0 || b_rd2 !== 32'h10008000) begin
            $display("FAIL reset_mid_pend: got p1=%b stall=%b gp=%h, expected 0 0 10008000", b_p1, b_stall, b_rd2);
            miscompares++;
        end
    endtask

    initial begin
        idle_inputs();
        #2;
        test_reset();
        test_write();
        test_bypass();
        test_scoreboard();
        test_simultaneous();
        test_full_count();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
